// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        HELD         = 2'd2,
        RELEASE_PEND = 2'd3
    } btn_state_t;

    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_FUNC  = 2;

    // Counter width able to hold 0..v inclusive, never narrower than one bit.
    function automatic int cnt_width(input int v);
        return (v < 1) ? 1 : $clog2(v + 1);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, debounce counter, press/release FSM and
// optional auto-repeat (enabled by defining BTN_AUTOREPEAT_EN).
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int REPEAT_DELAY    = 50000,
    parameter int REPEAT_PERIOD   = 12500
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("btn_channel: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_reg;
    logic            sync;
    logic [DB_W-1:0] db_cnt_reg, db_cnt_next;
    logic            db_done;
    btn_state_t      state_reg, state_next;
    logic            level_reg, level_next;
    logic            press_reg, press_next;
    logic            release_reg, release_next;

    assign sync = sync_reg[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg    <= '0;
            db_cnt_reg  <= '0;
            state_reg   <= RELEASED;
            level_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[0], raw};
            db_cnt_reg  <= db_cnt_next;
            state_reg   <= state_next;
            level_reg   <= level_next;
            press_reg   <= press_next;
            release_reg <= release_next;
        end
    end

    // Any agreeing sample restarts the count; the count never passes DB_LAST.
    always_comb begin
        db_done     = (sync != level_reg) && (db_cnt_reg == DB_LAST);
        db_cnt_next = db_cnt_reg;
        if (sync == level_reg || db_done)
            db_cnt_next = '0;
        else if (db_cnt_reg != DB_LAST)
            db_cnt_next = db_cnt_reg + 1'b1;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            RELEASED:     if (db_done) state_next = HELD;
                          else if (sync) state_next = PRESS_PEND;
            PRESS_PEND:   if (db_done) state_next = HELD;
                          else if (!sync) state_next = RELEASED;
            HELD:         if (db_done) state_next = RELEASED;
                          else if (!sync) state_next = RELEASE_PEND;
            RELEASE_PEND: if (db_done) state_next = RELEASED;
                          else if (sync) state_next = HELD;
            default:      state_next = RELEASED;
        endcase
    end

    always_comb begin
        level_next   = (state_next == HELD) || (state_next == RELEASE_PEND);
        press_next   = db_done && !level_reg;
        release_next = db_done && level_reg;
    end

    assign btn_level   = level_reg;
    assign btn_press   = press_reg;
    assign btn_release = release_reg;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RP_W = cnt_width(REPEAT_DELAY);
    localparam logic [RP_W-1:0] RP_LAST   = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RP_RELOAD =
        RP_W'((REPEAT_DELAY >= REPEAT_PERIOD) ? (REPEAT_DELAY - REPEAT_PERIOD) : 0);

    logic [RP_W-1:0] rpt_cnt_reg, rpt_cnt_next;
    logic            rpt_pulse;
    logic            repeat_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_cnt_reg <= '0;
            repeat_reg  <= 1'b0;
        end else begin
            rpt_cnt_reg <= rpt_cnt_next;
            repeat_reg  <= press_next | rpt_pulse;
        end
    end

    // The pulse that would land on the release edge is dropped.
    always_comb begin
        rpt_cnt_next = rpt_cnt_reg;
        rpt_pulse    = 1'b0;
        if (press_next) begin
            rpt_cnt_next = '0;
        end else if (state_reg == HELD || state_reg == RELEASE_PEND) begin
            if (rpt_cnt_reg == RP_LAST) begin
                rpt_cnt_next = RP_RELOAD;
                rpt_pulse    = !release_next;
            end else if (rpt_cnt_reg < RP_LAST) begin
                rpt_cnt_next = rpt_cnt_reg + 1'b1;
            end
        end
    end

    assign btn_repeat = repeat_reg;
`else
    assign btn_repeat = press_reg;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Front-panel button conditioner: N_BTN independent btn_channel instances.
// Auto-repeat is built only when BTN_AUTOREPEAT_EN is defined.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int REPEAT_DELAY    = 50000,
    parameter int REPEAT_PERIOD   = 12500
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .raw         (btn_raw[gi]),
            .btn_level   (btn_level[gi]),
            .btn_press   (btn_press[gi]),
            .btn_release (btn_release[gi]),
            .btn_repeat  (btn_repeat[gi])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_button_conditioner;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_repeat;

    button_conditioner #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int press_cnt [N] = '{default: 0};
    int rel_cnt   [N] = '{default: 0};
    int rpt_cnt   [N] = '{default: 0};
    int rep_ne_press = 0;
    int rpt0_q[$];

    // Event monitor on the falling edge; cyc names the rising edge just passed.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (btn_press[i])   press_cnt[i] <= press_cnt[i] + 1;
            if (btn_release[i]) rel_cnt[i]   <= rel_cnt[i] + 1;
            if (btn_repeat[i])  rpt_cnt[i]   <= rpt_cnt[i] + 1;
        end
        if (btn_repeat != btn_press) rep_ne_press <= rep_ne_press + 1;
        if (btn_repeat[0]) rpt0_q.push_back(cyc);
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int bseq [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
    int base_p, base_r, base_q, p_cyc, n_exp, n_got;
    int base_e [N];
    int exp_off[$];

    initial begin
        // Reset state
        tick(3);
        check("rst_level",   btn_level,   0);
        check("rst_press",   btn_press,   0);
        check("rst_release", btn_release, 0);
        check("rst_repeat",  btn_repeat,  0);
        rst = 1'b0;
        tick(5);

        // A: clean press on bit 1 held 8 cycles
        btn_raw[1] = 1'b1;
        tick(5);
        check("A_level_early", btn_level, 0);
        tick(1);
        check("A_level", btn_level, 3'b010);
        check("A_press", btn_press, 3'b010);
        check("A_repeat", btn_repeat, 3'b010);
        tick(1);
        check("A_press_once", btn_press, 0);
        tick(1);
        btn_raw[1] = 1'b0;
        tick(5);
        check("A_rel_early", btn_release, 0);
        check("A_level_pend", btn_level, 3'b010);
        tick(1);
        check("A_release", btn_release, 3'b010);
        check("A_level_low", btn_level, 0);
        check("A_rel_no_rpt", btn_repeat, 0);
        tick(1);
        check("A_release_once", btn_release, 0);
        tick(5);

        // B: bouncing bit 0, press accepted only after four stable ones
        base_p = press_cnt[0];
        base_r = rel_cnt[0];
        base_q = rpt0_q.size();
        for (int k = 0; k < 9; k++) begin
            btn_raw[0] = (bseq[k] != 0);
            tick(1);
        end
        tick(1);
        check("B_no_early_press", press_cnt[0] - base_p, 0);
        check("B_level_early", btn_level, 0);
        tick(1);
        check("B_press", btn_press, 3'b001);
        p_cyc = cyc;
        tick(30);
        check("B_press_count", press_cnt[0] - base_p, 1);
        check("B_no_release", rel_cnt[0] - base_r, 0);

        // C: bit 0 held until P+40, repeats continue through release debounce
        tick(9);
        btn_raw[0] = 1'b0;
        tick(6);
        check("C_release", btn_release, 3'b001);
        check("C_rpt_on_release", btn_repeat, 0);
        tick(4);
        exp_off.delete();
        exp_off.push_back(0);
`ifdef BTN_AUTOREPEAT_EN
        for (int o = 10; o <= 43; o += 3) exp_off.push_back(o);
`endif
        n_exp = exp_off.size();
        n_got = rpt0_q.size() - base_q;
        check("C_rpt_count", n_got, n_exp);
        for (int k = 0; k < n_exp && k < n_got; k++)
            check($sformatf("C_rpt_%0d", k), rpt0_q[base_q + k] - p_cyc, exp_off[k]);

        // D: reset two cycles into PRESS_PEND with bit 2 held
        btn_raw[2] = 1'b1;
        tick(4);
        rst = 1'b1;
        base_p = press_cnt[2];
        tick(3);
        check("D_level_in_rst", btn_level, 0);
        rst = 1'b0;
        tick(5);
        check("D_no_early_press", press_cnt[2] - base_p, 0);
        check("D_level_early", btn_level, 0);
        tick(1);
        check("D_press", btn_press, 3'b100);
        check("D_level", btn_level, 3'b100);

        // E: all three rise together, then a 40-cycle hold
        btn_raw = '0;
        tick(10);
        for (int i = 0; i < N; i++) base_e[i] = rpt_cnt[i];
        base_p = press_cnt[1];
        btn_raw = 3'b111;
        tick(6);
        check("E_press", btn_press, 3'b111);
        check("E_repeat", btn_repeat, 3'b111);
        check("E_level", btn_level, 3'b111);
        tick(41);
`ifdef BTN_AUTOREPEAT_EN
        n_exp = 12;
`else
        n_exp = 1;
`endif
        check("E_rpt0_count", rpt_cnt[0] - base_e[0], n_exp);
        check("E_rpt2_count", rpt_cnt[2] - base_e[2], n_exp);
        check("E_press1_count", press_cnt[1] - base_p, 1);
        btn_raw = '0;
        tick(10);
`ifndef BTN_AUTOREPEAT_EN
        check("rpt_eq_press", rep_ne_press, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions the raw front-panel push buttons (left, right, function) before they reach the game controller. Each channel is synchronised, debounced and converted into a stable level, single-cycle press/release pulses and an optional auto-repeat pulse train. The game FSM consumes the pulses, so a held button moves the character at a controlled rate instead of once per 250-cycle tick.

## Interface
- N_BTN, 3, number of independent button channels; bit 0 left, bit 1 right, bit 2 function
- DEBOUNCE_CYCLES, 1000, consecutive stable samples required to accept a level change; must be ≥1
- REPEAT_DELAY, 50000, cycles from press pulse to first auto-repeat pulse; must be ≥1
- REPEAT_PERIOD, 12500, cycles between subsequent auto-repeat pulses; must be ≥1
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- btn_raw  in  N_BTN  asynchronous raw button inputs, active-high
- btn_level  out  N_BTN  debounced level
- btn_press  out  N_BTN  one-cycle pulse on accepted 0→1 transition
- btn_release  out  N_BTN  one-cycle pulse on accepted 1→0 transition
- btn_repeat  out  N_BTN  press pulse OR auto-repeat pulses while held

## Operation
- Per channel, fully independent; no cross-channel interaction.
- Synchroniser: 2-flop chain on btn_raw; debounce logic sees only the second flop (sync).
- Debounce counter: while sync ≠ btn_level, count up; while sync = btn_level, clear to 0. When count reaches DEBOUNCE_CYCLES−1 with sync still ≠ level, level toggles and counter clears. A single disagreeing-to-agreeing glitch restarts the count.
- Channel FSM: RELEASED, PRESS_PEND, HELD, RELEASE_PEND. RELEASED→PRESS_PEND on sync=1; PRESS_PEND→RELEASED on sync=0; PRESS_PEND→HELD on debounce complete (press pulse); HELD→RELEASE_PEND on sync=0; RELEASE_PEND→HELD on sync=1; RELEASE_PEND→RELEASED on debounce complete (release pulse).
- Auto-repeat counter: cleared on press pulse; in HELD or RELEASE_PEND increments each cycle; pulse emitted when counter hits REPEAT_DELAY, then every REPEAT_PERIOD thereafter (counter reloads to REPEAT_DELAY−REPEAT_PERIOD after each repeat). Counter frozen, no pulses, in RELEASED/PRESS_PEND.
- btn_repeat = press pulse | auto-repeat pulse; never asserted in the same cycle as btn_release.
- Counter widths: $clog2(param+1); counters never wrap, saturate at terminal value.

## Timing
- Reset values: sync flops 0, btn_level 0, all pulse outputs 0, all counters 0, FSM RELEASED.
- All outputs registered.
- Latency: btn_raw rising edge at cycle t (clean) → btn_level and btn_press high at cycle t+2+DEBOUNCE_CYCLES; same for release.
- btn_press/btn_release/btn_repeat high for exactly one cycle per event.
- Button held across rst deassertion: treated as a fresh press; press pulse DEBOUNCE_CYCLES+2 cycles after rst low (sync reset to 0).
- rst asserted mid-debounce or mid-repeat: all state cleared next edge, no pending pulse emitted.
- Simultaneous presses on several channels: each channel pulses independently in the same cycle.

## Configuration
- BTN_AUTOREPEAT_EN defined: auto-repeat counter and pulses as above.
- Not defined: repeat counter not instantiated, REPEAT_* ignored, btn_repeat is identical to btn_press.

## Structure
- Shared package btn_pkg: channel FSM state enum (RELEASED, PRESS_PEND, HELD, RELEASE_PEND), channel index constants BTN_LEFT=0, BTN_RIGHT=1, BTN_FUNC=2.
- One sub-module, btn_channel: synchroniser, debounce counter, FSM, repeat counter for a single button; top generates N_BTN instances.

## Test plan
Parameters DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, BTN_AUTOREPEAT_EN defined unless stated.
- Clean press on bit 1 at cycle 20, held 8 cycles → btn_level[1] and btn_press[1] rise at cycle 26; press pulse 1 cycle; release pulse 6 cycles after raw drop.
- Bouncing input 1,0,1,1,0,1,1,1,1 on bit 0 → no press until four consecutive 1s on sync; exactly one press pulse, no release pulse.
- Bit 0 held 40 cycles after press pulse at cycle P → btn_repeat[0] at P, P+10, P+13, P+16, …; stops after release begins debouncing only on debounce completion.
- rst asserted 2 cycles into a PRESS_PEND with button held, deasserted at cycle R → press pulse at R+6, no pulse during reset.
- All three bits rise together → three press pulses in the same cycle; build without BTN_AUTOREPEAT_EN → btn_repeat equals btn_press throughout, no extra pulses after 40-cycle hold.
